pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_rst_pkg.sv | 24 ++
 rtl/pll_reset_sequencer_sync_2ff.sv | 27 ++
 rtl/pll_reset_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg
//   Shared definitions for pll_reset_sequencer: the FSM state encoding,
//   default timing constants and a counter-width helper.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_REL_SYS   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  localparam int unsigned DEF_PLL_RST_CYCLES     = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_STAGE_GAP          = 8;
  localparam int unsigned DEF_LOCK_TIMEOUT       = 65536;

  // $clog2(n) bits hold 0..n-1; keep at least one bit for tiny parameters.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level signal.
//   Ports:
//     clk   - destination clock
//     rst_n - asynchronous active-low reset, clears both flops
//     d     - asynchronous input
//     q     - synchronized output (two clk edges of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Pulses the PLL reset, waits for a stable lock, then releases the
//   control-domain reset and, STAGE_GAP cycles later, the datapath reset.
//   Any loss of lock after release drops both resets and re-qualifies lock;
//   a lock that never arrives re-pulses the PLL after LOCK_TIMEOUT cycles.
//   Ports:
//     clk           - free-running board reference clock (not a PLL output)
//     rst_n         - asynchronous active-low reset
//     pll_locked    - PLL lock flag, asynchronous to clk
//     pll_rst       - active-high PLL reset
//     sys_rst_n     - active-low reset, control domain
//     dsp_rst_n     - active-low reset, datapath domain
//     ready         - high only in RUN
//     lock_loss_cnt - saturating count of lock losses after release
//     timeout_cnt   - saturating count of lock timeouts
//   The last two ports exist only when PLL_RST_SEQ_STATUS_EN is defined.
//   LOCK_STABLE_CYCLES must be at least 2.
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned STAGE_GAP          = DEF_STAGE_GAP,
  parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       dsp_rst_n,
  output logic       ready
`ifdef PLL_RST_SEQ_STATUS_EN
  ,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] timeout_cnt
`endif
);

  localparam int unsigned RST_W  = cnt_w(PLL_RST_CYCLES);
  localparam int unsigned TO_W   = cnt_w(LOCK_TIMEOUT);
  localparam int unsigned STAB_W = cnt_w(LOCK_STABLE_CYCLES);
  localparam int unsigned GAP_W  = cnt_w(STAGE_GAP);

  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock counts as the first stable
  // cycle, so STABLE itself only needs LOCK_STABLE_CYCLES-1 more.
  localparam logic [STAB_W-1:0] STAB_LAST =
    STAB_W'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);

  state_t            state;
  logic              lock_s;
  logic [RST_W-1:0]  rst_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [STAB_W-1:0] stab_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Each counter only advances in its own state and is zeroed on the way
  // out, so every state is entered with all counters at zero. Counters stop
  // at their terminal value because that value always forces a transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_PLL_RST;
      rst_cnt   <= '0;
      to_cnt    <= '0;
      stab_cnt  <= '0;
      gap_cnt   <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      dsp_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      case (state)
        ST_PLL_RST: begin
          if (rst_cnt == RST_LAST) begin
            state   <= ST_WAIT_LOCK;
            rst_cnt <= '0;
            pll_rst <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end

        ST_WAIT_LOCK: begin
          // Lock wins over a simultaneous timeout.
          if (lock_s) begin
            state  <= ST_STABLE;
            to_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            state   <= ST_PLL_RST;
            to_cnt  <= '0;
            pll_rst <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        ST_STABLE: begin
          if (!lock_s) begin
            state    <= ST_WAIT_LOCK;
            stab_cnt <= '0;
          end else if (stab_cnt == STAB_LAST) begin
            state     <= ST_REL_SYS;
            stab_cnt  <= '0;
            sys_rst_n <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + STAB_W'(1);
          end
        end

        ST_REL_SYS: begin
          if (!lock_s) begin
            state     <= ST_WAIT_LOCK;
            gap_cnt   <= '0;
            sys_rst_n <= 1'b0;
          end else if (gap_cnt == GAP_LAST) begin
            state     <= ST_RUN;
            gap_cnt   <= '0;
            dsp_rst_n <= 1'b1;
            ready     <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        ST_RUN: begin
          if (!lock_s) begin
            state     <= ST_WAIT_LOCK;
            sys_rst_n <= 1'b0;
            dsp_rst_n <= 1'b0;
            ready     <= 1'b0;
          end
        end

        default: begin
          // Unused encodings recover through a full PLL reset.
          state     <= ST_PLL_RST;
          rst_cnt   <= '0;
          to_cnt    <= '0;
          stab_cnt  <= '0;
          gap_cnt   <= '0;
          pll_rst   <= 1'b1;
          sys_rst_n <= 1'b0;
          dsp_rst_n <= 1'b0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_RST_SEQ_STATUS_EN
  logic lock_loss_evt;
  logic timeout_evt;

  // Same conditions the FSM uses for these two transitions.
  assign lock_loss_evt = ((state == ST_REL_SYS) || (state == ST_RUN)) && !lock_s;
  assign timeout_evt   = (state == ST_WAIT_LOCK) && !lock_s && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_cnt <= '0;
      timeout_cnt   <= '0;
    end else begin
      if (lock_loss_evt && (lock_loss_cnt != 8'hFF))
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
      if (timeout_evt && (timeout_cnt != 8'hFF))
        timeout_cnt <= timeout_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Self-checking bench for pll_reset_sequencer. Expected latencies and
//   levels are pushed to a queue when stimulus is applied and popped when
//   the corresponding output event is observed. Status-counter checks are
//   compiled only when PLL_RST_SEQ_STATUS_EN is defined.
module tb_pll_reset_sequencer;

  localparam int PRC = 16;
  localparam int LSC = 32;
  localparam int SG  = 8;
  localparam int LT  = 512;
  localparam int LIM = 4 * LT;

  logic clk = 1'b0;
  logic rst_n;
  logic pll_locked;
  logic pll_rst, sys_rst_n, dsp_rst_n, ready;
`ifdef PLL_RST_SEQ_STATUS_EN
  logic [7:0] lock_loss_cnt, timeout_cnt;
`endif

  typedef struct {
    string name;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (PRC),
    .LOCK_STABLE_CYCLES (LSC),
    .STAGE_GAP          (SG),
    .LOCK_TIMEOUT       (LT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .dsp_rst_n  (dsp_rst_n),
    .ready      (ready)
`ifdef PLL_RST_SEQ_STATUS_EN
    ,
    .lock_loss_cnt (lock_loss_cnt),
    .timeout_cnt   (timeout_cnt)
`endif
  );

  function automatic logic sig(input int w);
    case (w)
      0:       return pll_rst;
      1:       return sys_rst_n;
      2:       return dsp_rst_n;
      default: return ready;
    endcase
  endfunction

  // Counts negedges until output w reaches lvl; -1 if the bound expires.
  task automatic wait_sig(input int w, input logic lvl, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sig(w) !== lvl && n < limit);
    if (sig(w) !== lvl) n = -1;
  endtask

  // Pulses rst_n for a few cycles and releases it on a negedge.
  task automatic do_reset(input logic lk);
    @(negedge clk);
    rst_n = 1'b0;
    pll_locked = lk;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    pll_locked = 1'b1;
    exp_q.push_back('{"reset_pll_rst", 1});
    exp_q.push_back('{"reset_sys_rst_n", 0});
    exp_q.push_back('{"reset_dsp_rst_n", 0});
    exp_q.push_back('{"reset_ready", 0});
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n = int'(sig(i));
      n_tests++;
      if (n !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", e.name, n, e.val);
      end
    end
`ifdef PLL_RST_SEQ_STATUS_EN
    n_tests++;
    if (lock_loss_cnt !== 8'd0 || timeout_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_status: got %0d/%0d expected 0/0", lock_loss_cnt, timeout_cnt);
    end
`endif
  endtask

  task automatic test_power_up;
    int n;
    exp_q.push_back('{"pwr_pll_rst_len", PRC});
    exp_q.push_back('{"pwr_sys_delay", LSC});
    exp_q.push_back('{"pwr_dsp_gap", SG});
    exp_q.push_back('{"pwr_ready", 1});
    @(negedge clk);
    rst_n = 1'b1;
    wait_sig(0, 1'b0, LIM, n);
    e = exp_q.pop_front(); n_tests++;
    if (n !== e.val) begin n_fail++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.val); end
    wait_sig(1, 1'b1, LIM, n);
    e = exp_q.pop_front(); n_tests++;
    if (n !== e.val) begin n_fail++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.val); end
    wait_sig(2, 1'b1, LIM, n);
    e = exp_q.pop_front(); n_tests++;
    if (n !== e.val) begin n_fail++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.val); end
    n = int'(ready & sys_rst_n & ~pll_rst);
    e = exp_q.pop_front(); n_tests++;
    if (n !== e.val) begin n_fail++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.val); end
  endtask

  task automatic test_lock_loss;
    int n;
    repeat (5) @(negedge clk);
    exp_q.push_back('{"loss_latency", 3});
    exp_q.push_back('{"loss_all_low", 0});
    pll_locked = 1'b0;
    wait_sig(1, 1'b0, 10, n);
    e = exp_q.pop_front(); n_tests++;
    if (n !== e.val) begin n_fail++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.val); end
    n = int'(dsp_rst_n | ready | pll_rst);
    e = exp_q.pop_front(); n_tests++;
    if (n !== e.val) begin n_fail++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.val); end
`ifdef PLL_RST_SEQ_STATUS_EN
    @(negedge clk);
    n_tests++;
    if (lock_loss_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL loss_count: got %0d expected 1", lock_loss_cnt);
    end
`endif
    exp_q.push_back('{"relock_sys_delay", LSC + 2});
    exp_q.push_back('{"relock_dsp_gap", SG});
    @(negedge clk);
    pll_locked = 1'b1;
    wait_sig(1, 1'b1, LIM, n);
    e = exp_q.pop_front(); n_tests++;
    if (n !== e.val) begin n_fail++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.val); end
    wait_sig(2, 1'b1, LIM, n);
    e = exp_q.pop_front(); n_tests++;
    if (n !== e.val) begin n_fail++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.val); end
  endtask

  task automatic test_back_to_back;
    int n;
    int iters;
`ifdef PLL_RST_SEQ_STATUS_EN
    iters = 300;
`else
    iters = 4;
`endif
    for (int i = 0; i < iters; i++) begin
      exp_q.push_back('{"b2b_loss_latency", 3});
      pll_locked = 1'b0;
      wait_sig(1, 1'b0, 10, n);
      e = exp_q.pop_front(); n_tests++;
      if (n !== e.val) begin n_fail++; $display("FAIL %s[%0d]: got %0d expected %0d", e.name, i, n, e.val); end
      exp_q.push_back('{"b2b_relock_delay", LSC + 2});
      pll_locked = 1'b1;
      wait_sig(1, 1'b1, LIM, n);
      e = exp_q.pop_front(); n_tests++;
      if (n !== e.val) begin n_fail++; $display("FAIL %s[%0d]: got %0d expected %0d", e.name, i, n, e.val); end
    end
`ifdef PLL_RST_SEQ_STATUS_EN
    pll_locked = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if (lock_loss_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL loss_count_sat: got %0d expected 255", lock_loss_cnt);
    end
    pll_locked = 1'b1;
`endif
  endtask

  task automatic test_lock_glitch;
    int n;
    do_reset(1'b0);
    wait_sig(0, 1'b0, LIM, n);
    repeat (4) @(negedge clk);
    pll_locked = 1'b1;
    repeat (LSC - 1) @(negedge clk);
    pll_locked = 1'b0;
    @(negedge clk);
    exp_q.push_back('{"glitch_sys_held", 0});
    exp_q.push_back('{"glitch_fresh_delay", LSC + 2});
    n = int'(sys_rst_n);
    pll_locked = 1'b1;
    e = exp_q.pop_front(); n_tests++;
    if (n !== e.val) begin n_fail++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.val); end
    wait_sig(1, 1'b1, LIM, n);
    e = exp_q.pop_front(); n_tests++;
    if (n !== e.val) begin n_fail++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.val); end
  endtask

  task automatic test_timeout;
    int n;
    do_reset(1'b0);
    exp_q.push_back('{"to_first_pulse", PRC});
    wait_sig(0, 1'b0, LIM, n);
    e = exp_q.pop_front(); n_tests++;
    if (n !== e.val) begin n_fail++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.val); end
    for (int k = 1; k <= 2; k++) begin
      exp_q.push_back('{"to_wait", LT});
      exp_q.push_back('{"to_pulse", PRC});
      wait_sig(0, 1'b1, LIM, n);
      e = exp_q.pop_front(); n_tests++;
      if (n !== e.val) begin n_fail++; $display("FAIL %s[%0d]: got %0d expected %0d", e.name, k, n, e.val); end
`ifdef PLL_RST_SEQ_STATUS_EN
      n_tests++;
      if (timeout_cnt !== 8'(k)) begin
        n_fail++;
        $display("FAIL to_count: got %0d expected %0d", timeout_cnt, k);
      end
`endif
      wait_sig(0, 1'b0, LIM, n);
      e = exp_q.pop_front(); n_tests++;
      if (n !== e.val) begin n_fail++; $display("FAIL %s[%0d]: got %0d expected %0d", e.name, k, n, e.val); end
    end
  endtask

  task automatic test_async_reset;
    int n;
    do_reset(1'b1);
    wait_sig(1, 1'b1, LIM, n);
    repeat (2) @(negedge clk);
    exp_q.push_back('{"arst_in_rel_sys", 1});
    exp_q.push_back('{"arst_outputs", 4'b0001});
    exp_q.push_back('{"arst_restart_pulse", PRC});
    n = int'(sys_rst_n & ~dsp_rst_n);
    e = exp_q.pop_front(); n_tests++;
    if (n !== e.val) begin n_fail++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.val); end
    #2 rst_n = 1'b0;
    #1 n = int'({ready, dsp_rst_n, sys_rst_n, pll_rst});
    e = exp_q.pop_front(); n_tests++;
    if (n !== e.val) begin n_fail++; $display("FAIL %s: got %0h expected %0h", e.name, n, e.val); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_sig(0, 1'b0, LIM, n);
    e = exp_q.pop_front(); n_tests++;
    if (n !== e.val) begin n_fail++; $display("FAIL %s: got %0d expected %0d", e.name, n, e.val); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_loss();
    test_back_to_back();
    test_lock_glitch();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
